i2s_chain_ctrl: RTL and testbench

//  Sequencer for the I2S rx -> DSP -> tx audio chain.
//  - Qualifies the incoming ws_i frame timing and holds the DSP in reset until the link is locked.
//  - Synchronises and debounces the freqSetting/scaleFactor switches.
//  - Applies new settings only inside a click-free gain ramp: down, apply, up.
//  - Restarts the chain on DSP error or frame-timing loss.

---
 rtl/i2s_ctrl_pkg.sv | 19 +
 rtl/i2s_frame_monitor.sv | 42 ++++
 rtl/i2s_chain_ctrl.sv | 178 +++++++++++++++++
 tb/tb_i2s_chain_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_ctrl_pkg.sv
// Shared state encodings and gain constants for the I2S chain sequencer.
package i2s_ctrl_pkg;

   localparam int unsigned GAIN_W   = 4;
   localparam int unsigned STATE_W  = 3;
   localparam int unsigned SW_W     = 8;

   localparam logic [GAIN_W-1:0] GAIN_MAX  = '1;
   localparam logic [GAIN_W-1:0] GAIN_ZERO = '0;
   localparam logic [GAIN_W-1:0] GAIN_ONE  = GAIN_W'(1);

   // Sequencer states; encodings are visible on the debug LEDs.
   localparam logic [STATE_W-1:0] ST_HOLD      = 3'd0;
   localparam logic [STATE_W-1:0] ST_RAMP_UP   = 3'd1;
   localparam logic [STATE_W-1:0] ST_RUN       = 3'd2;
   localparam logic [STATE_W-1:0] ST_RAMP_DOWN = 3'd3;
   localparam logic [STATE_W-1:0] ST_APPLY     = 3'd4;

endpackage

// File: rtl/i2s_frame_monitor.sv
// Word-select frame qualifier: ws falling-edge tick, frame length check, first-tick flag.
module i2s_frame_monitor #(
   parameter int unsigned WIDTH = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ws_i,
   output logic tick_c,
   output logic good_c,
   output logic bad_c,
   output logic seen
);

   localparam int unsigned LEN_SAT  = 2 * WIDTH + 1;
   localparam int unsigned LEN_GOOD = 2 * WIDTH - 1;
   localparam int unsigned LEN_W    = $clog2(LEN_SAT + 1);

   logic             ws_q;
   logic [LEN_W-1:0] len_cnt;

   assign tick_c = ws_q & ~ws_i;
   assign good_c = tick_c & seen & (len_cnt == LEN_W'(LEN_GOOD));
   assign bad_c  = tick_c & ~good_c & seen;

   // Edge register, saturating frame length counter and first-tick flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ws_q    <= 1'b0;
         len_cnt <= '0;
         seen    <= 1'b0;
      end else begin
         ws_q <= ws_i;
         if (tick_c) begin
            len_cnt <= '0;
            seen    <= 1'b1;
         end else if (len_cnt != LEN_W'(LEN_SAT)) begin
            len_cnt <= len_cnt + LEN_W'(1);
         end
      end
   end

endmodule

// File: rtl/i2s_chain_ctrl.sv
// Sequencer for the I2S rx -> DSP -> tx chain: link lock, switch debounce,
// click-free settings changes via a gain ramp, and restart on faults.
module i2s_chain_ctrl
   import i2s_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH         = 16,
   parameter int unsigned LOCK_FRAMES   = 8,
   parameter int unsigned STABLE_FRAMES = 4
) (
   input  logic              sclk_i,
   input  logic              rst_n_i,
   input  logic              ws_i,
   input  logic [3:0]        freqSetting_i,
   input  logic [3:0]        scaleFactor_i,
   input  logic              errorLED_i,
   output logic [3:0]        freqSetting_o,
   output logic [3:0]        scaleFactor_o,
   output logic              dspRst_n_o,
   output logic [GAIN_W-1:0] gain_o,
   output logic              locked_o,
   output logic [2:0]        state_o
);

   localparam int unsigned LOCK_W = $clog2(LOCK_FRAMES + 1);
   localparam int unsigned ST_W   = $clog2(STABLE_FRAMES + 1);

   logic tick_c;
   logic good_c;
   logic bad_c;
   logic seen;

   logic [SW_W-1:0]    sync1_q;
   logic [SW_W-1:0]    sync2_q;
   logic [ST_W-1:0]    st_cnt_q;
   logic               req_c;
   logic               fault_c;

   logic [STATE_W-1:0] state_q,     state_d;
   logic [GAIN_W-1:0]  gain_q,      gain_d;
   logic [LOCK_W-1:0]  lock_cnt_q,  lock_cnt_d;
   logic [SW_W-1:0]    applied_q,   applied_d;
   logic               dsp_rst_n_q, dsp_rst_n_d;
   logic               locked_q;

   i2s_frame_monitor #(
      .WIDTH (WIDTH)
   ) u_frame_monitor (
      .clk    (sclk_i),
      .rst_n  (rst_n_i),
      .ws_i   (ws_i),
      .tick_c (tick_c),
      .good_c (good_c),
      .bad_c  (bad_c),
      .seen   (seen)
   );

   // Two-stage synchroniser and stability counter for the settings switches.
   always_ff @(posedge sclk_i) begin
      if (!rst_n_i) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         st_cnt_q <= '0;
      end else begin
         sync1_q <= {freqSetting_i, scaleFactor_i};
         sync2_q <= sync1_q;
         if (sync1_q != sync2_q) begin
            st_cnt_q <= '0;
         end else if (tick_c && (st_cnt_q != ST_W'(STABLE_FRAMES))) begin
            st_cnt_q <= st_cnt_q + ST_W'(1);
         end
      end
   end

   assign req_c   = (st_cnt_q == ST_W'(STABLE_FRAMES)) && (sync2_q != applied_q);
   assign fault_c = errorLED_i | bad_c;

   // Next-state and next-output logic; a fault outside HOLD overrides everything.
   always_comb begin
      state_d     = state_q;
      gain_d      = gain_q;
      lock_cnt_d  = lock_cnt_q;
      applied_d   = applied_q;
      dsp_rst_n_d = dsp_rst_n_q;

      case (state_q)
         ST_HOLD: begin
            gain_d      = GAIN_ZERO;
            dsp_rst_n_d = 1'b0;
            if (bad_c || (tick_c && !seen)) begin
               lock_cnt_d = '0;
            end else if (good_c) begin
               if (lock_cnt_q == LOCK_W'(LOCK_FRAMES - 1)) begin
                  state_d     = ST_RAMP_UP;
                  dsp_rst_n_d = 1'b1;
                  applied_d   = sync2_q;
                  lock_cnt_d  = '0;
               end else begin
                  lock_cnt_d = lock_cnt_q + LOCK_W'(1);
               end
            end
         end
         ST_RAMP_UP: begin
            if (gain_q == GAIN_MAX) begin
               state_d = ST_RUN;
            end else if (tick_c) begin
               gain_d = gain_q + GAIN_ONE;
               if (gain_q == GAIN_MAX - GAIN_ONE) begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            gain_d = GAIN_MAX;
            if (req_c) begin
               state_d = ST_RAMP_DOWN;
            end
         end
         ST_RAMP_DOWN: begin
            if (gain_q == GAIN_ZERO) begin
               state_d   = ST_APPLY;
               applied_d = sync2_q;
            end else if (tick_c) begin
               gain_d = gain_q - GAIN_ONE;
               if (gain_q == GAIN_ONE) begin
                  state_d   = ST_APPLY;
                  applied_d = sync2_q;
               end
            end
         end
         ST_APPLY: begin
            gain_d = GAIN_ZERO;
            if (tick_c) begin
               state_d = ST_RAMP_UP;
            end
         end
         default: begin
            state_d     = ST_HOLD;
            gain_d      = GAIN_ZERO;
            dsp_rst_n_d = 1'b0;
            lock_cnt_d  = '0;
         end
      endcase

      if ((state_q != ST_HOLD) && fault_c) begin
         state_d     = ST_HOLD;
         gain_d      = GAIN_ZERO;
         dsp_rst_n_d = 1'b0;
         lock_cnt_d  = '0;
      end
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge sclk_i) begin
      if (!rst_n_i) begin
         state_q     <= ST_HOLD;
         gain_q      <= GAIN_ZERO;
         lock_cnt_q  <= '0;
         applied_q   <= '0;
         dsp_rst_n_q <= 1'b0;
         locked_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         gain_q      <= gain_d;
         lock_cnt_q  <= lock_cnt_d;
         applied_q   <= applied_d;
         dsp_rst_n_q <= dsp_rst_n_d;
         locked_q    <= (state_d != ST_HOLD);
      end
   end

   assign freqSetting_o = applied_q[7:4];
   assign scaleFactor_o = applied_q[3:0];
   assign dspRst_n_o    = dsp_rst_n_q;
   assign gain_o        = gain_q;
   assign locked_o      = locked_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_i2s_chain_ctrl.sv
// Directed bench for the I2S chain sequencer: lock-up, settings change, bounce,
// frame glitch, DSP error and reset during a ramp.
module tb_i2s_chain_ctrl;

   logic       sclk;
   logic       rst_n;
   logic       ws;
   logic [3:0] freq_sw;
   logic [3:0] scale_sw;
   logic       err;
   logic [3:0] freq_out;
   logic [3:0] scale_out;
   logic       dsp_rst_n;
   logic [3:0] gain;
   logic       locked;
   logic [2:0] state;

   localparam logic [2:0] S_HOLD = 3'd0;
   localparam logic [2:0] S_UP   = 3'd1;
   localparam logic [2:0] S_RUN  = 3'd2;
   localparam logic [2:0] S_DOWN = 3'd3;
   localparam logic [2:0] S_APP  = 3'd4;

   int n_checks;
   int n_fail;
   int tick_cnt;
   int glitch_req;
   int glitch_done;
   logic gen_en;
   logic ws_q_m;
   logic tick_next;

   // {state, dspRst_n, locked, gain, freq, scale}
   logic [16:0] obs;
   logic [16:0] exp_v;
   assign obs = {state, dsp_rst_n, locked, gain, freq_out, scale_out};

   i2s_chain_ctrl dut (
      .sclk_i        (sclk),
      .rst_n_i       (rst_n),
      .ws_i          (ws),
      .freqSetting_i (freq_sw),
      .scaleFactor_i (scale_sw),
      .errorLED_i    (err),
      .freqSetting_o (freq_out),
      .scaleFactor_o (scale_out),
      .dspRst_n_o    (dsp_rst_n),
      .gain_o        (gain),
      .locked_o      (locked),
      .state_o       (state)
   );

   initial begin
      sclk = 1'b0;
      forever #5 sclk = ~sclk;
   end

   // Frame generator: each frame starts with the ws falling edge; low half then high half.
   initial begin
      ws = 1'b0;
      forever begin
         if (!gen_en) begin
            @(posedge sclk);
            #1 ws = 1'b0;
         end else begin
            int len;
            len = (glitch_req != glitch_done) ? 30 : 32;
            if (len == 30) glitch_done++;
            for (int i = 0; i < len; i++) begin
               @(posedge sclk);
               #1 ws = (i >= len / 2);
            end
         end
      end
   end

   // Reference tick model: predicts at the falling clock edge whether the next rising edge ticks.
   always @(negedge sclk) begin
      tick_next = ws_q_m & ~ws & rst_n;
      ws_q_m    = rst_n ? ws : 1'b0;
   end

   always @(posedge sclk) begin
      if (tick_next) tick_cnt++;
   end

   task automatic wait_ticks(input int n);
      int target;
      int budget;
      target = tick_cnt + n;
      budget = 40 * n + 40;
      while ((tick_cnt < target) && (budget > 0)) begin
         @(negedge sclk);
         budget--;
      end
      if (tick_cnt < target) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_ticks: reached %0d ticks, required %0d", tick_cnt, target);
      end
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      freq_sw  = 4'h0;
      scale_sw = 4'h0;
      err      = 1'b0;
      repeat (4) @(negedge sclk);
      exp_v = {S_HOLD, 1'b0, 1'b0, 4'd0, 4'h0, 4'h0};
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL reset_values: got %h required %h", obs, exp_v); end
      @(posedge sclk);
      #1 rst_n = 1'b1;
      @(negedge sclk);
      gen_en = 1'b1;
   endtask

   task automatic test_lockup();
      wait_ticks(8);
      exp_v = {S_HOLD, 1'b0, 1'b0, 4'd0, 4'h0, 4'h0};
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL lock_before_9th: got %h required %h", obs, exp_v); end
      wait_ticks(1);
      exp_v = {S_UP, 1'b1, 1'b1, 4'd0, 4'h0, 4'h0};
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL lock_release: got %h required %h", obs, exp_v); end
      wait_ticks(14);
      exp_v = {S_UP, 1'b1, 1'b1, 4'd14, 4'h0, 4'h0};
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL lock_ramp14: got %h required %h", obs, exp_v); end
      wait_ticks(1);
      exp_v = {S_RUN, 1'b1, 1'b1, 4'd15, 4'h0, 4'h0};
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL lock_run: got %h required %h", obs, exp_v); end
   endtask

   task automatic test_setting_change();
      freq_sw  = 4'h3;
      scale_sw = 4'h5;
      wait_ticks(3);
      exp_v = {S_RUN, 1'b1, 1'b1, 4'd15, 4'h0, 4'h0};
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL chg_tick3: got %h required %h", obs, exp_v); end
      wait_ticks(1);
      @(negedge sclk);
      exp_v = {S_DOWN, 1'b1, 1'b1, 4'd15, 4'h0, 4'h0};
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL chg_ramp_down: got %h required %h", obs, exp_v); end
      wait_ticks(14);
      exp_v = {S_DOWN, 1'b1, 1'b1, 4'd1, 4'h0, 4'h0};
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL chg_down1: got %h required %h", obs, exp_v); end
      wait_ticks(1);
      exp_v = {S_APP, 1'b1, 1'b1, 4'd0, 4'h3, 4'h5};
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL chg_apply: got %h required %h", obs, exp_v); end
      wait_ticks(1);
      exp_v = {S_UP, 1'b1, 1'b1, 4'd0, 4'h3, 4'h5};
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL chg_ramp_up: got %h required %h", obs, exp_v); end
      wait_ticks(15);
      exp_v = {S_RUN, 1'b1, 1'b1, 4'd15, 4'h3, 4'h5};
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL chg_run: got %h required %h", obs, exp_v); end
   endtask

   task automatic test_bounce();
      exp_v = {S_RUN, 1'b1, 1'b1, 4'd15, 4'h3, 4'h5};
      for (int k = 1; k <= 16; k++) begin
         freq_sw  = (k % 2 == 1) ? 4'hA : 4'h3;
         scale_sw = (k % 2 == 1) ? 4'hC : 4'h5;
         repeat (20) @(negedge sclk);
         n_checks++;
         if (obs !== exp_v) begin n_fail++; $display("FAIL bounce_%0d: got %h required %h", k, obs, exp_v); end
      end
      wait_ticks(5);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL bounce_settle: got %h required %h", obs, exp_v); end
   endtask

   task automatic test_frame_glitch();
      glitch_req++;
      wait_ticks(1);
      exp_v = {S_RUN, 1'b1, 1'b1, 4'd15, 4'h3, 4'h5};
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL glitch_pre: got %h required %h", obs, exp_v); end
      wait_ticks(1);
      exp_v = {S_HOLD, 1'b0, 1'b0, 4'd0, 4'h3, 4'h5};
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL glitch_fault: got %h required %h", obs, exp_v); end
      wait_ticks(3);
      glitch_req++;
      wait_ticks(2);
      wait_ticks(7);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL glitch_hold_clear: got %h required %h", obs, exp_v); end
      wait_ticks(1);
      exp_v = {S_UP, 1'b1, 1'b1, 4'd0, 4'h3, 4'h5};
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL glitch_relock: got %h required %h", obs, exp_v); end
   endtask

   task automatic test_dsp_error();
      wait_ticks(7);
      exp_v = {S_UP, 1'b1, 1'b1, 4'd7, 4'h3, 4'h5};
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL err_gain7: got %h required %h", obs, exp_v); end
      err = 1'b1;
      @(negedge sclk);
      err = 1'b0;
      exp_v = {S_HOLD, 1'b0, 1'b0, 4'd0, 4'h3, 4'h5};
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL err_fault: got %h required %h", obs, exp_v); end
      wait_ticks(7);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL err_relock7: got %h required %h", obs, exp_v); end
      wait_ticks(1);
      exp_v = {S_UP, 1'b1, 1'b1, 4'd0, 4'h3, 4'h5};
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL err_relock8: got %h required %h", obs, exp_v); end
      wait_ticks(15);
      exp_v = {S_RUN, 1'b1, 1'b1, 4'd15, 4'h3, 4'h5};
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL err_run: got %h required %h", obs, exp_v); end
   endtask

   task automatic test_reset_mid_ramp();
      freq_sw  = 4'h1;
      scale_sw = 4'h2;
      wait_ticks(4);
      @(negedge sclk);
      exp_v = {S_DOWN, 1'b1, 1'b1, 4'd15, 4'h3, 4'h5};
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL rst_ramp_down: got %h required %h", obs, exp_v); end
      wait_ticks(3);
      exp_v = {S_DOWN, 1'b1, 1'b1, 4'd12, 4'h3, 4'h5};
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL rst_gain12: got %h required %h", obs, exp_v); end
      @(posedge sclk);
      #1 rst_n = 1'b0;
      @(negedge sclk);
      @(negedge sclk);
      exp_v = {S_HOLD, 1'b0, 1'b0, 4'd0, 4'h0, 4'h0};
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL rst_mid_ramp: got %h required %h", obs, exp_v); end
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      tick_cnt    = 0;
      glitch_req  = 0;
      glitch_done = 0;
      gen_en      = 1'b0;
      ws_q_m      = 1'b0;
      tick_next   = 1'b0;
      test_reset();
      test_lockup();
      test_setting_change();
      test_bounce();
      test_frame_glitch();
      test_dsp_error();
      test_reset_mid_ramp();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
